// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
//   rx_valid / rx_data / rx_ready : byte stream, a byte moves on a CLK edge
//                                   where rx_valid && rx_ready
//   wr_en / wr_addr / wr_data     : one-cycle word write strobe, word-aligned
//                                   byte address, write word
// slave  : loader side (consumes bytes, drives memory writes)
// master : stream source / memory side
interface prog_loader_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   modport slave (
      input  rx_valid,
      input  rx_data,
      output rx_ready,
      output wr_en,
      output wr_addr,
      output wr_data
   );

   modport master (
      output rx_valid,
      output rx_data,
      input  rx_ready,
      input  wr_en,
      input  wr_addr,
      input  wr_data
   );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader. Accepts a length-prefixed, checksummed byte
// stream (CNT_LO, CNT_HI, 4*N little-endian payload bytes, CSUM), packs the
// payload into 32-bit words and writes word k to byte address 4*k. The CPU
// is held in reset until the whole image is in memory and the checksum
// matched.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : byte stream in, instruction-memory write port out
//   cpu_rst    : high keeps the CPU in reset (everywhere except DONE)
//   done       : image loaded and checksum matched
//   err        : oversize count or checksum mismatch
//
// state  | meaning
// -------+------------------------------------------------------------
// HDR0   | waiting for CNT_LO
// HDR1   | waiting for CNT_HI, then range-check the word count
// DATA   | collecting payload bytes, one memory write per 4 bytes
// CSUM   | waiting for the checksum byte
// DONE   | image good, CPU released; terminal until reset
// ERR    | bad count or checksum, CPU held; terminal until reset
module prog_loader #(
   parameter int MEM_DEPTH = 256
) (
   input  logic          CLK,
   input  logic          RST_N,
   prog_loader_if.slave  bus,
   output logic          cpu_rst,
   output logic          done,
   output logic          err
);

   localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        ready_nxt;

   logic [7:0]  cnt_lo;
   logic [15:0] words_left;   // down-counter, terminal at the last word
   logic [15:0] word_idx;     // index of the word being assembled
   logic [1:0]  byte_cnt;
   logic [7:0]  sum;
   logic [23:0] word_buf;     // bytes 0..2 of the current word, byte 0 lowest

   logic        take;
   logic        word_last;
   logic [15:0] n_cnt;

   assign take      = bus.rx_valid && bus.rx_ready;
   assign word_last = take && (state == S_DATA) && (byte_cnt == 2'd3);
   assign n_cnt     = {bus.rx_data, cnt_lo};

   always_comb begin
      state_nxt = state;
      case (state)
         S_HDR0: begin
            if (take) state_nxt = S_HDR1;
         end
         S_HDR1: begin
            if (take) begin
               if ({1'b0, n_cnt} > DEPTH) state_nxt = S_ERR;
               else if (n_cnt == 16'd0)   state_nxt = S_CSUM;
               else                       state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (word_last && (words_left == 16'd1)) state_nxt = S_CSUM;
         end
         S_CSUM: begin
            if (take) begin
               if (bus.rx_data == sum) state_nxt = S_DONE;
               else                    state_nxt = S_ERR;
            end
         end
         default: state_nxt = state;
      endcase
   end

   // rx_ready is registered from the next state so it drops on the very
   // edge that enters DONE or ERR, and stays low throughout reset.
   assign ready_nxt = (state_nxt == S_HDR0) || (state_nxt == S_HDR1) ||
                      (state_nxt == S_DATA) || (state_nxt == S_CSUM);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state        <= S_HDR0;
         bus.rx_ready <= 1'b0;
         bus.wr_en    <= 1'b0;
         bus.wr_addr  <= 32'd0;
         bus.wr_data  <= 32'd0;
         cnt_lo       <= 8'd0;
         words_left   <= 16'd0;
         word_idx     <= 16'd0;
         byte_cnt     <= 2'd0;
         sum          <= 8'd0;
         word_buf     <= 24'd0;
      end else begin
         state        <= state_nxt;
         bus.rx_ready <= ready_nxt;
         bus.wr_en    <= 1'b0;
         if (take) begin
            case (state)
               S_HDR0: cnt_lo <= bus.rx_data;
               S_HDR1: begin
                  words_left <= n_cnt;
                  word_idx   <= 16'd0;
                  byte_cnt   <= 2'd0;
                  sum        <= 8'd0;
               end
               S_DATA: begin
                  sum      <= sum + bus.rx_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt != 2'd3) begin
                     word_buf <= {bus.rx_data, word_buf[23:8]};
                  end else begin
                     // Committed before the checksum is known; cpu_rst
                     // stays high so a bad image never runs.
                     bus.wr_en   <= 1'b1;
                     bus.wr_data <= {bus.rx_data, word_buf};
                     bus.wr_addr <= {14'd0, word_idx, 2'b00};
                     word_idx    <= word_idx + 16'd1;
                     words_left  <= words_left - 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign cpu_rst = (state != S_DONE);
   assign done    = (state == S_DONE);
   assign err     = (state == S_ERR);

endmodule
